// File: rtl/tx_word_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared UART word arbiter.
// master is the arbiter's view; slave is the view of the requesters and transmitter.
interface tx_word_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned GW = $clog2(NUM_REQ);

    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_done;
    logic [15:0]           tx_data;
    logic                  tx_valid;
    logic                  tx_done;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        input  req_data, req_valid, tx_done,
        output req_ready, req_done, tx_data, tx_valid, grant_id, busy, timeout_err
    );

    modport slave (
        output req_data, req_valid, tx_done,
        input  req_ready, req_done, tx_data, tx_valid, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/tx_word_arbiter.sv
// Round-robin arbiter sharing one 16-bit UART word transmitter among NUM_REQ requesters,
// with a saturating watchdog that aborts a transfer whose completion never arrives.
module tx_word_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input logic               clk,
    input logic               rst,
    tx_word_arbiter_if.master bus
);
    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WdogLast = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

    state_e               state_q, state_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        winner;
    logic                 any_valid;
    logic                 expire;
    logic [WW-1:0]        wdog_q, wdog_d;
    logic [15:0]          tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    // Search upward from the requester after the last grant, wrapping at NUM_REQ.
    always_comb begin
        logic [31:0]   idx;
        logic [GW-1:0] cand;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(last_grant_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = GW'(idx);
            if (!any_valid && bus.req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign expire = (wdog_q == WdogLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_valid) state_d = StWait;
            StWait:  if (bus.tx_done || expire) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_valid_d   = 1'b0;
        ready_d      = '0;
        done_d       = '0;
        timeout_d    = 1'b0;
        tx_data_d    = tx_data_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (winner == GW'(i)) begin
                            tx_data_d = bus.req_data[16*i +: 16];
                        end
                    end
                    grant_d    = winner;
                    tx_valid_d = 1'b1;
                    ready_d    = NUM_REQ'(1) << winner;
                    wdog_d     = '0;
                end
            end
            StWait: begin
                if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
                // Completion beats a watchdog expiry landing in the same cycle.
                if (bus.tx_done) begin
                    done_d       = NUM_REQ'(1) << grant_q;
                    last_grant_d = grant_q;
                end else if (expire) begin
                    timeout_d    = 1'b1;
                    last_grant_d = grant_q;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            ready_q      <= '0;
            done_q       <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            wdog_q       <= '0;
        end else begin
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.req_ready   = ready_q;
    assign bus.req_done    = done_q;
    assign bus.timeout_err = timeout_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_q;
endmodule
